// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared VGA display constants, pixel type and fetch FSM states
//             used by the timing port and the line fetcher.
//  Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;

    // Row value the timing port presents on the line just before row 0.
    localparam logic [8:0] ROW_PRE_FRAME = 9'd511;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_line_buf.sv
`default_nettype none
// ============================================================================
//  Module   : vga_line_buf
//  Purpose  : Ping-pong scanline store, two lines of DEPTH 12-bit pixels.
//             Synchronous write port, asynchronous read port. Reads with
//             an address beyond the line return black.
//  Revision : 1.0  initial release
// ============================================================================
module vga_line_buf #(
    parameter int DEPTH = vga_pkg::H_ACTIVE
) (
    input  logic        clk,
    input  logic        we,
    input  logic        wsel,
    input  logic [9:0]  waddr,
    input  logic [11:0] wdata,
    input  logic        rsel,
    input  logic [9:0]  raddr,
    output logic [11:0] rdata
);
    import vga_pkg::*;

    rgb_t r_mem [0:1][0:DEPTH-1];

    // Store one fetched pixel into the selected line.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wsel][waddr] <= rgb_t'(wdata);
        end
    end

    // Asynchronous read so the pixel tracks row/column in the same cycle.
    always_comb begin
        rdata = 12'h000;
        if (raddr < 10'(DEPTH)) begin
            rdata = r_mem[rsel][raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_line_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : vga_line_fetch
//  Purpose  : Prefetches each scanline from the framebuffer over a req/ack
//             interface into a ping-pong line buffer and serves the pixel
//             for the current row/column with zero latency.
//  Revision : 1.0  initial release
// ============================================================================
module vga_line_fetch #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int ADDR_W   = 19,
    parameter int FB_BASE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [8:0]        row,
    input  logic [9:0]        column,
    input  logic              read,
    output logic [11:0]       data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [11:0]       mem_rdata,
    output logic              busy,
    output logic              underrun
);
    import vga_pkg::*;

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [8:0]        r_line;
    logic [9:0]        r_x;
    logic [1:0]        r_valid;
    logic              r_read_q;
    logic              r_underrun;
    logic [ADDR_W-1:0] r_mem_addr;

    logic              w_trig_t0;
    logic              w_trig_t1;
    logic              w_trigger;
    logic [8:0]        w_next_line;
    logic              w_last;
    logic              w_start;
    logic              w_write;
    logic              w_done;
    logic [11:0]       w_buf_rdata;

    // Base word address of line k: k*640 expressed as k*512 + k*128.
    function automatic logic [ADDR_W-1:0] line_base(input logic [8:0] k);
        logic [ADDR_W-1:0] kw;
        kw = ADDR_W'(k);
        return ADDR_W'(FB_BASE) + (kw << 9) + (kw << 7);
    endfunction

    // Fetch triggers: pre-frame line start fetches line 0, a display-start
    // edge on any row but the last fetches the following line.
    always_comb begin
        w_trig_t0   = (row == ROW_PRE_FRAME) && (column == 10'd0);
        w_trig_t1   = read && !r_read_q && (row < 9'(V_ACTIVE - 1));
        w_trigger   = w_trig_t0 || w_trig_t1;
        w_next_line = w_trig_t0 ? 9'd0 : row + 9'd1;
        w_last      = (r_x == 10'(H_ACTIVE - 1));
    end

    // Next-state and control decode; a trigger always wins over an ack so
    // an aborted fetch never writes its same-cycle word.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_write      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_start      = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (w_trigger) begin
                    w_start      = 1'b1;
                    w_next_state = ST_FETCH;
                end else if (mem_ack) begin
                    w_write = 1'b1;
                    if (w_last) begin
                        w_done       = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Address generation, line bookkeeping, valid bits and sticky underrun.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid    <= 2'b00;
            r_mem_addr <= '0;
            r_underrun <= 1'b0;
            r_read_q   <= 1'b0;
            r_x        <= 10'd0;
            r_line     <= 9'd0;
        end else begin
            r_read_q <= read;
            if (w_start) begin
                r_valid[w_next_line[0]] <= 1'b0;
                r_x                     <= 10'd0;
                r_line                  <= w_next_line;
                r_mem_addr              <= line_base(w_next_line);
            end else if (w_write) begin
                r_x        <= r_x + 10'd1;
                r_mem_addr <= r_mem_addr + 1'b1;
                if (w_done) begin
                    r_valid[r_line[0]] <= 1'b1;
                end
            end
            if ((w_trigger && (r_state == ST_FETCH)) || (read && !r_valid[row[0]])) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // Writes are blocked during reset so an aborted fetch leaves no trace.
    vga_line_buf #(
        .DEPTH (H_ACTIVE)
    ) u_line_buf (
        .clk   (clk),
        .we    (w_write && rst),
        .wsel  (r_line[0]),
        .waddr (r_x),
        .wdata (mem_rdata),
        .rsel  (row[0]),
        .raddr (column),
        .rdata (w_buf_rdata)
    );

    // Pixel output: black unless the line for this row is complete.
    always_comb begin
        data = r_valid[row[0]] ? w_buf_rdata : 12'h000;
    end

    assign mem_req  = (r_state == ST_FETCH);
    assign busy     = (r_state == ST_FETCH);
    assign mem_addr = r_mem_addr;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: doc/vga_line_fetch.md
Name: vga_line_fetch

Overview:
- Pixel source directly upstream of the VGA timing port.
- Prefetches each 640-pixel scanline from a 12-bit RGB framebuffer over a req/ack memory interface into a ping-pong line buffer.
- Returns the pixel for the port's current row/column on `data`, combinationally and in the same cycle.
- Runs in the 25 MHz pixel clock domain.

Parameters:
- H_ACTIVE, 640: visible pixels per line; words fetched per line.
- V_ACTIVE, 480: visible lines per frame.
- ADDR_W, 19: framebuffer word-address width.
- FB_BASE, 0: word address of pixel (0,0).

Ports:
- clk  in  1  pixel clock, 25 MHz.
- rst  in  1  reset; synchronous, active-low.
- row  in  9  visible row from the timing port; wraps to 511 on the line before row 0.
- column  in  10  visible column from the timing port.
- read  in  1  display-active strobe from the timing port.
- data  out  12  RGB pixel {r,g,b} for (row, column).
- mem_req  out  1  fetch request, level-held.
- mem_addr  out  ADDR_W  framebuffer word address.
- mem_ack  in  1  transfer accepted; mem_rdata is valid this cycle.
- mem_rdata  in  12  framebuffer word.
- busy  out  1  a line fetch is in progress.
- underrun  out  1  sticky; a line was displayed before its fetch completed.

Behaviour:
- Reset (rst==0 at posedge clk):
  - state=IDLE; mem_req=0, mem_addr=0, busy=0, underrun=0.
  - Both buffer valid bits cleared. Buffer contents are not reset.
- Buffering:
  - Two line buffers, 640x12 each, asynchronous read.
  - Line L is always stored in buffer L[0].
  - data = valid[row[0]] ? buf[row[0]][column] : 12'h000.
  - Zero cycles of latency from row/column to data.
  - Out-of-range column (>=H_ACTIVE) returns 0.
- Fetch triggers, evaluated each cycle:
  - T0: row==9'd511 && column==10'd0 starts a fetch of line 0.
  - T1: rising edge of read (read==1, read_q==0) with row < V_ACTIVE-1 starts a fetch of line row+1.
  - No other event starts a fetch.
- Fetch start, for line k:
  - valid[k[0]] <= 0.
  - x counter <= 0; line register <= k.
  - mem_addr <= FB_BASE + k*H_ACTIVE. The multiply by a constant is done with shift-add, truncated to ADDR_W.
  - mem_req <= 1; state=FETCH; busy=1.
- FSM:
  - IDLE -> FETCH on a trigger.
  - In FETCH, each cycle with mem_req && mem_ack: write mem_rdata to buf[k[0]][x]; x++; mem_addr++.
  - Up to one word per cycle; mem_req stays high and mem_addr is stable while mem_ack is low.
  - On the ack of word x==H_ACTIVE-1: mem_req<=0, valid[k[0]]<=1, busy<=0, state=IDLE.
- Trigger while in FETCH (previous fetch not finished):
  - underrun<=1.
  - Abort the current fetch; its buffer stays invalid.
  - Restart immediately for the new line. The same-cycle ack of the old fetch is discarded.
- Underrun:
  - Also set if read==1 while valid[row[0]]==0.
  - Cleared only by reset.
- Reset mid-fetch: mem_req drops the next cycle; no further buffer writes occur.
- Timing budget:
  - Fetch of line L+1 starts at the display start of line L; 800 cycles are available.
  - Line 0 has 944 cycles available.
  - A memory sustaining 640 acks within 800 cycles never underruns.

Decomposition:
- Shared package vga_pkg holds H_ACTIVE, V_ACTIVE, H_TOTAL=800, V_TOTAL=525, the 12-bit RGB type and ROW_PRE_FRAME=9'd511.
- The timing port consumes the same constants from vga_pkg.
- One sub-module: vga_line_buf, a dual-buffer 2x640x12 RAM with a synchronous write port and an asynchronous read port.
- The FSM, address generation and trigger logic stay in vga_line_fetch.

Test Plan:
- Reset held 3 cycles, then released with row=100, column=300, read=0 -> mem_req=0, busy=0, underrun=0, data=12'h000.
- Zero-wait memory (mem_ack=1, rdata=addr[11:0]) with FB_BASE=0; drive row=511, column=0 -> mem_addr runs 0..639 on consecutive cycles, busy=1 for 640 cycles. Then at row=0, column=5, data=12'h005.
- Read rises at row=0 -> line-1 fetch from address 640. At row=1, column=0, data=640[11:0]=12'h280. Line 0 stays readable from buf0 throughout.
- mem_ack toggling 1-of-2 cycles -> mem_addr holds while ack is low, no word is skipped or duplicated, and line 5 completes in 1279 cycles with underrun=0.
- mem_ack held 0, then read rises for the next line -> underrun=1 and stays 1, a new fetch restarts at the new line's base address, and data=0 while the line is displayed invalid.
- rst asserted mid-fetch at x=200 -> next cycle mem_req=0, busy=0, and both valid bits are 0.
